// File: rtl/vga_frame_capture_if.sv
// vga_frame_capture_if: valid/ready write port from the frame grabber to data memory.
// The master drives the word and its address. The slave answers with wr_ready.
interface vga_frame_capture_if;
  logic         wr_valid;
  logic         wr_ready;
  logic [31:0]  wr_addr;
  logic [191:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: samples a VGA stream on the pixel strobe and rebuilds the raster
// position from the sync edges. It captures a WIN_W x WIN_H window of one armed frame.
// Each pixel becomes one 192-bit vector word (R,G,B in lanes 0..2) and is written to
// memory through a small write FIFO.
// Sync edges are found by comparing the current sample with the registered previous one.
// A pixel therefore carries the h_cnt/v_cnt values from before the update on its own strobe.
// Optional build macro VGA_CAPTURE_CHECKSUM_EN adds a 32-bit R+G+B checksum output.
module vga_frame_capture #(
  parameter int unsigned H_BP       = 48,
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned WIN_W      = 100,
  parameter int unsigned WIN_H      = 100,
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_en,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic [7:0]                 r_in,
  input  logic [7:0]                 g_in,
  input  logic [7:0]                 b_in,
  input  logic                       arm,
  vga_frame_capture_if.master        wr,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overflow,
  output logic                       truncated
`ifdef VGA_CAPTURE_CHECKSUM_EN
  ,
  output logic [31:0]                checksum
`endif
);

  localparam int unsigned CW = 16;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] H_LO  = CW'(H_BP);
  localparam logic [CW-1:0] H_HI  = CW'(H_BP + H_ACT);
  localparam logic [CW-1:0] V_LO  = CW'(V_BP);
  localparam logic [CW-1:0] V_HI  = CW'(V_BP + V_ACT);
  localparam logic [CW-1:0] WW    = CW'(WIN_W);
  localparam logic [CW-1:0] WH    = CW'(WIN_H);
  localparam logic [CW-1:0] WW_M1 = CW'(WIN_W - 1);
  localparam logic [CW-1:0] WH_M1 = CW'(WIN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_hs_prev;
  logic            r_vs_prev;
  logic [CW-1:0]   r_h_cnt;
  logic [CW-1:0]   r_v_cnt;
  logic            w_hs_rise;
  logic            w_vs_rise;
  logic [CW-1:0]   w_x;
  logic [CW-1:0]   w_y;
  logic            w_in_win;
  logic            w_last;
  logic            w_push_req;
  logic            w_arm_ok;

  logic [31:0]     r_addr;
  logic            r_overflow;
  logic            r_truncated;

  logic            r_st_valid;
  logic [31:0]     r_st_addr;
  logic [23:0]     r_st_rgb;

  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [55:0]     r_mem [FIFO_DEPTH];
  logic [55:0]     w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  assign w_hs_rise  = pix_en & hsync & ~r_hs_prev;
  assign w_vs_rise  = pix_en & vsync & ~r_vs_prev;
  assign w_x        = r_h_cnt - H_LO;
  assign w_y        = r_v_cnt - V_LO;
  assign w_in_win   = (r_h_cnt >= H_LO) && (r_h_cnt < H_HI) &&
                      (r_v_cnt >= V_LO) && (r_v_cnt < V_HI) &&
                      (w_x < WW) && (w_y < WH);
  assign w_last     = w_in_win && (w_x == WW_M1) && (w_y == WH_M1);
  // A vsync edge ends the capture window, so the pixel on that strobe is not taken.
  assign w_push_req = pix_en && (r_state == S_CAPTURE) && w_in_win && !w_vs_rise;
  assign w_arm_ok   = arm && (r_state == S_IDLE);

  // Sync edge history and raster position counters, advanced once per pixel strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else if (pix_en) begin
      r_hs_prev <= hsync;
      r_vs_prev <= vsync;
      if (w_hs_rise)
        r_h_cnt <= '0;
      else if (r_h_cnt != '1)
        r_h_cnt <= r_h_cnt + CW'(1);
      if (w_vs_rise)
        r_v_cnt <= '0;
      else if (w_hs_rise)
        r_v_cnt <= r_v_cnt + CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (arm) w_state_nxt = S_WAIT_VS;
      S_WAIT_VS: if (w_vs_rise) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_vs_rise || (w_push_req && w_last)) w_state_nxt = S_FLUSH;
      S_FLUSH:   if (w_empty && !r_st_valid) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (r_state != S_IDLE);
    frame_done = (r_state == S_DONE);
  end

  // Sticky status flags and the running word address (+3 per window pixel)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_truncated <= 1'b0;
      r_addr      <= '0;
    end else if (w_arm_ok) begin
      r_overflow  <= 1'b0;
      r_truncated <= 1'b0;
      r_addr      <= BASE_ADDR;
    end else begin
      if (w_drop)
        r_overflow <= 1'b1;
      if ((r_state == S_CAPTURE) && w_vs_rise)
        r_truncated <= 1'b1;
      if (w_push_req)
        r_addr <= r_addr + 32'd3;
    end
  end

  assign overflow  = r_overflow;
  assign truncated = r_truncated;

  // One-clk staging register between the strobe sample and the FIFO write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st_valid <= 1'b0;
      r_st_addr  <= '0;
      r_st_rgb   <= '0;
    end else begin
      r_st_valid <= w_push_req;
      if (w_push_req) begin
        r_st_addr <= r_addr;
        r_st_rgb  <= {b_in, g_in, r_in};
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && wr.wr_ready;
  assign w_push  = r_st_valid && (!w_full || w_pop);
  assign w_drop  = r_st_valid && w_full && !w_pop;

  // FIFO read/write pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // FIFO storage: the entry is {address, B, G, R}
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= {r_st_addr, r_st_rgb};
  end

  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign wr.wr_valid = !w_empty;
  assign wr.wr_addr  = w_empty ? '0 : w_head[55:24];
  assign wr.wr_data  = w_empty ? '0 :
                       {120'd0, w_head[23:16], 24'd0, w_head[15:8], 24'd0, w_head[7:0]};

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running R+G+B sum over every window pixel, including pixels the FIFO drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_checksum <= '0;
    else if (w_arm_ok)
      r_checksum <= '0;
    else if (w_push_req)
      r_checksum <= r_checksum + 32'(r_in) + 32'(g_in) + 32'(b_in);
  end

  assign checksum = r_checksum;
`endif

endmodule
